// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF fetch port, the data port and the shared memory port.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic [DW-1:0]   mem_rdata;

    logic            busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and data access.
// Data wins collisions; a saturating counter forces IF through after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]         starve_q, starve_d;
    logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [MEM_LAT-1:0] tag_own_d_q, tag_own_d_d;

    logic              if_gnt_c;
    logic              d_gnt_c;
    logic              store_c;
    logic [AW-1:0]     mem_addr_c;
    logic [DW-1:0]     mem_wdata_c;
    logic [DW/8-1:0]   mem_wstrb_c;
    logic              last_vld;
    logic              last_own_d;
    logic              if_rvalid_c;
    logic              d_rvalid_c;

    // Grants are held low while reset is asserted so nothing reaches memory.
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (!rst) begin
            if (bus.if_req && bus.d_req) begin
                if (starve_q >= STARVE_LIM) begin
                    if_gnt_c = 1'b1;
                end else begin
                    d_gnt_c = 1'b1;
                end
            end else begin
                if_gnt_c = bus.if_req;
                d_gnt_c  = bus.d_req;
            end
        end
    end

    always_comb begin
        store_c     = d_gnt_c & bus.d_we;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_wstrb_c = '0;
        if (d_gnt_c) begin
            mem_addr_c = bus.d_addr;
        end else if (if_gnt_c) begin
            mem_addr_c = bus.if_addr;
        end
        if (store_c) begin
            mem_wdata_c = bus.d_wdata;
            mem_wstrb_c = bus.d_wstrb;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_c || !bus.if_req) begin
            starve_d = '0;
        end else if (d_gnt_c && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Stage 0 captures the owner of a read issued this cycle; stores leave it empty.
    always_comb begin
        tag_vld_d   = tag_vld_q;
        tag_own_d_d = tag_own_d_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_vld_d[i]   = tag_vld_q[i-1];
            tag_own_d_d[i] = tag_own_d_q[i-1];
        end
        tag_vld_d[0]   = if_gnt_c | (d_gnt_c & ~bus.d_we);
        tag_own_d_d[0] = d_gnt_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            tag_vld_q   <= '0;
            tag_own_d_q <= '0;
        end else begin
            starve_q    <= starve_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_d_q <= tag_own_d_d;
        end
    end

    always_comb begin
        last_vld    = tag_vld_q[MEM_LAT-1];
        last_own_d  = tag_own_d_q[MEM_LAT-1];
        if_rvalid_c = last_vld & ~last_own_d;
        d_rvalid_c  = last_vld & last_own_d;
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_req   = if_gnt_c | d_gnt_c;
    assign bus.mem_we    = store_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_wstrb = mem_wstrb_c;

    assign bus.if_rvalid = if_rvalid_c;
    assign bus.d_rvalid  = d_rvalid_c;
    assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid_c ? bus.mem_rdata : '0;
    assign bus.busy      = |tag_vld_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases,
// and random traffic checked against a queue-based model of in-flight reads.
module tb_mem_port_arbiter;
    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus();

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: returns mem_fn(addr) LAT cycles after a read, noise otherwise.
    logic [LAT-1:0] mp_v;
    logic [31:0]    mp_d [LAT];
    logic [31:0]    noise;
    initial begin
        mp_v  = '0;
        noise = 32'hA5A5_5A5A;
    end
    always @(posedge clk) begin
        for (int i = 1; i < LAT; i++) begin
            mp_v[i] <= mp_v[i-1];
            mp_d[i] <= mp_d[i-1];
        end
        mp_v[0] <= bus.mem_req & ~bus.mem_we;
        mp_d[0] <= mem_fn(bus.mem_addr);
        noise   <= $urandom | 32'h1;
    end
    assign bus.mem_rdata = mp_v[LAT-1] ? mp_d[LAT-1] : noise;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic        own_d;
        logic [31:0] addr;
    } rd_t;

    rd_t  inflight[$];
    int   starve    = 0;
    logic m_ig      = 1'b0;
    logic m_dg      = 1'b0;
    logic last_ig   = 1'b0;
    int   rv_seen   = 0;
    int   both_seen = 0;

    task automatic model_cycle();
        logic        eig, edg, st, e_irv, e_drv, e_busy;
        logic [31:0] e_ird, e_drd;
        rd_t         r;
        last_ig = bus.if_gnt;
        if (bus.if_rvalid | bus.d_rvalid) rv_seen++;
        if (bus.if_rvalid & bus.d_rvalid) both_seen++;
        if (rst) begin
            chk_b("rst_if_gnt",    bus.if_gnt,    1'b0);
            chk_b("rst_d_gnt",     bus.d_gnt,     1'b0);
            chk_b("rst_mem_req",   bus.mem_req,   1'b0);
            chk_b("rst_mem_we",    bus.mem_we,    1'b0);
            chk_b("rst_if_rvalid", bus.if_rvalid, 1'b0);
            chk_b("rst_d_rvalid",  bus.d_rvalid,  1'b0);
            chk_w("rst_if_rdata",  bus.if_rdata,  32'h0);
            chk_w("rst_d_rdata",   bus.d_rdata,   32'h0);
            chk_b("rst_busy",      bus.busy,      1'b0);
            inflight.delete();
            starve = 0;
            m_ig   = 1'b0;
            m_dg   = 1'b0;
        end else begin
            eig = 1'b0;
            edg = 1'b0;
            if (bus.if_req && bus.d_req) begin
                if (starve == SMAX) eig = 1'b1;
                else                edg = 1'b1;
            end else if (bus.if_req) begin
                eig = 1'b1;
            end else if (bus.d_req) begin
                edg = 1'b1;
            end
            st     = edg & bus.d_we;
            e_busy = (inflight.size() != 0);
            e_irv  = 1'b0;
            e_drv  = 1'b0;
            e_ird  = 32'h0;
            e_drd  = 32'h0;
            if (inflight.size() != 0 && inflight[0].due == cyc) begin
                r = inflight.pop_front();
                if (r.own_d) begin
                    e_drv = 1'b1;
                    e_drd = mem_fn(r.addr);
                end else begin
                    e_irv = 1'b1;
                    e_ird = mem_fn(r.addr);
                end
            end
            chk_b("if_gnt",   bus.if_gnt,  eig);
            chk_b("d_gnt",    bus.d_gnt,   edg);
            chk_b("mem_req",  bus.mem_req, eig | edg);
            chk_b("mem_we",   bus.mem_we,  st);
            if (eig) chk_w("mem_addr_if", bus.mem_addr, bus.if_addr);
            if (edg) chk_w("mem_addr_d",  bus.mem_addr, bus.d_addr);
            if (st)  chk_w("mem_wdata",   bus.mem_wdata, bus.d_wdata);
            if (!(edg && !bus.d_we))
                chk_w("mem_wstrb", 32'(bus.mem_wstrb), st ? 32'(bus.d_wstrb) : 32'h0);
            chk_b("busy",      bus.busy,      e_busy);
            chk_b("if_rvalid", bus.if_rvalid, e_irv);
            chk_b("d_rvalid",  bus.d_rvalid,  e_drv);
            chk_w("if_rdata",  bus.if_rdata,  e_ird);
            chk_w("d_rdata",   bus.d_rdata,   e_drd);
            chk_b("rvalid_exclusive", bus.if_rvalid & bus.d_rvalid, 1'b0);
            if (eig) inflight.push_back('{cyc + LAT, 1'b0, bus.if_addr});
            if (edg && !bus.d_we) inflight.push_back('{cyc + LAT, 1'b1, bus.d_addr});
            if (eig || !bus.if_req) starve = 0;
            else if (edg)           starve = (starve < SMAX) ? starve + 1 : SMAX;
            m_ig = eig;
            m_dg = edg;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dws;
        logic        e_ig;
        logic        e_dg;
        logic        e_we;
        logic [3:0]  e_ws;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[8];

    logic [9:0] seq;
    logic       ip, dp;

    initial begin
        tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100};
        tbl[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h2000};
        tbl[2] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h104};
        tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,   32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 32'h40};
        tbl[4] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tbl[5] = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h44,   32'h12345678, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 32'h44};
        tbl[6] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h48,   32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h48};
        tbl[7] = '{1'b1, 32'h108, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h108};

        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_wstrb = 4'h0;
        repeat (2) step();
        rst = 1'b0;
        idle(1);

        // Vector table starting from a cleared starvation counter.
        for (int i = 0; i < 8; i++) begin
            bus.if_req  = tbl[i].ifr;
            bus.if_addr = tbl[i].ia;
            bus.d_req   = tbl[i].dr;
            bus.d_we    = tbl[i].dwe;
            bus.d_addr  = tbl[i].da;
            bus.d_wdata = tbl[i].dwd;
            bus.d_wstrb = tbl[i].dws;
            @(negedge clk);
            chk_b("tbl_if_gnt",    bus.if_gnt, tbl[i].e_ig);
            chk_b("tbl_d_gnt",     bus.d_gnt,  tbl[i].e_dg);
            chk_b("tbl_mem_we",    bus.mem_we, tbl[i].e_we);
            chk_w("tbl_mem_wstrb", 32'(bus.mem_wstrb), 32'(tbl[i].e_ws));
            if (tbl[i].e_ig | tbl[i].e_dg) chk_w("tbl_mem_addr", bus.mem_addr, tbl[i].e_addr);
            if (tbl[i].e_we) chk_w("tbl_mem_wdata", bus.mem_wdata, tbl[i].dwd);
            model_cycle();
            @(posedge clk);
            #1;
        end
        idle(LAT + 2);

        // Store: acknowledged by d_gnt only, no response and no busy.
        rv_seen     = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_wstrb = 4'b0011;
        step();
        idle(LAT + 2);
        chk_w("store_no_rvalid", 32'(rv_seen), 32'h0);

        // Reset while an IF read is in flight: its response must never appear.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        step();
        rst         = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        rv_seen     = 0;
        repeat (2) step();
        rst         = 1'b0;
        idle(LAT + 3);
        chk_w("rst_drop_rvalid", 32'(rv_seen), 32'h0);

        // Both requesters held: IF forced through after SMAX data grants.
        idle(1);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h3000;
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            seq[i] = last_ig;
        end
        chk_w("starve_seq", 32'(seq), 32'h210);
        idle(LAT + 2);

        // Alternating back-to-back reads: six responses, never two at once.
        rv_seen   = 0;
        both_seen = 0;
        for (int i = 0; i < 6; i++) begin
            bus.if_req  = (i % 2 == 0);
            bus.d_req   = (i % 2 == 1);
            bus.d_we    = 1'b0;
            bus.if_addr = 32'h1000 + 32'(4 * i);
            bus.d_addr  = 32'h2000 + 32'(4 * i);
            step();
        end
        idle(LAT + 2);
        chk_w("pipe_rvalid_count", 32'(rv_seen), 32'd6);
        chk_w("pipe_both_rvalid",  32'(both_seen), 32'h0);

        // Random traffic; requests are held until the model grants them.
        ip = 1'b0;
        dp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip          = 1'b1;
                bus.if_addr = $urandom & 32'h0000_FFFC;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp          = 1'b1;
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_addr  = $urandom & 32'h0003_FFFF;
                bus.d_wdata = $urandom;
                bus.d_wstrb = bus.d_we ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            bus.if_req = ip;
            bus.d_req  = dp;
            rst        = ($urandom_range(0, 399) == 0);
            step();
            if (m_ig) ip = 1'b0;
            if (m_dg) dp = 1'b0;
        end
        rst = 1'b0;
        idle(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported, fixed-latency memory between the instruction-fetch stage (IF) and the data-access stage (MEM) of the RV32I pipeline. It grants at most one request per cycle, gives data accesses priority, and bounds instruction-fetch starvation with a counter. It tracks in-flight reads in a latency-matched tag pipeline so each read response is steered back to the requester that issued it.

## Interface
Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- MEM_LAT, 1, cycles from an accepted read to `mem_rdata` being valid; legal range 1..4.
- STARVE_MAX, 4, consecutive data grants allowed while `if_req` is pending before IF is forced through; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; held until granted.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid (registered).
- if_rdata  out  DW  IF read data.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_wstrb  in  DW/8  byte-lane enables for stores.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  load data valid (registered).
- d_rdata  out  DW  load data.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wstrb  out  DW/8  memory byte enables.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the read.
- busy  out  1  any read in flight (OR of tag valids).

## Operation
Arbitration runs every cycle and is combinational:
- Only one of `if_req`/`d_req` high: grant that requester.
- Both high and `starve_cnt < STARVE_MAX`: grant data.
- Both high and `starve_cnt == STARVE_MAX`: grant IF.
- `if_gnt` and `d_gnt` are never both 1.

Memory port:
- `mem_req = if_gnt | d_gnt`.
- Address, write data and strobes are muxed from the granted requester.
- `mem_we = d_gnt & d_we`.
- IF accesses always drive `mem_we=0` and `mem_wstrb=0`.

Starvation counter `starve_cnt` (4 bits):
- Increments on a cycle with `d_gnt & if_req`.
- Clears on `if_gnt` or whenever `if_req=0`.
- Saturates at STARVE_MAX.

Tag pipeline: MEM_LAT stages, each holding {valid, owner}.
- Stage 0 loads {1, IF} on `if_gnt`, {1, D} on `d_gnt & ~d_we`, and {0, x} otherwise.
- Stages shift every cycle; there is no backpressure.
- Stores occupy no tag. `d_gnt` is a store's only acknowledgement.

Responses:
- `if_rvalid = last.valid & owner==IF`; `d_rvalid = last.valid & owner==D`, where `last` is the final tag stage.
- `if_rdata` and `d_rdata` equal `mem_rdata` when their own rvalid is 1, and 0 otherwise.
- Responses return in issue order.

Reset:
- All tags cleared and `starve_cnt=0`.
- Reads in flight are dropped; no rvalid is produced for them after reset.
- During reset, `if_gnt`, `d_gnt` and `mem_req` are forced to 0.

## Timing
- Reset values: all grants 0, both rvalids 0, both rdatas 0, `mem_req=0`, `mem_we=0`, `busy=0`.
- Grant latency: 0 cycles. A request seen in cycle t is granted in cycle t if it wins arbitration.
- Read latency: a read granted in cycle t asserts rvalid during cycle t+MEM_LAT, for exactly one cycle.
- Throughput: one access per cycle. Back-to-back reads produce back-to-back rvalids.
- Simultaneous events: a grant in cycle t and a response to an older read in the same cycle are independent and both occur.
- A requester that drops `req` before its grant has the request discarded. Requesters must not do this, but it is not an error condition.
- Worst-case IF wait with both requesters continuously active: STARVE_MAX+1 cycles.

## Test plan
- Reset mid-flight, MEM_LAT=2: grant an IF read at cycle 5, assert `rst` at cycle 6 → no `if_rvalid` at cycle 7; `busy=0` and all outputs 0 during reset.
- IF only, MEM_LAT=1: `if_req=1`, `if_addr=0x100`, memory returns 0x00000013 → `if_gnt=1` in cycle 0, `mem_addr=0x100`, `if_rvalid=1` with `if_rdata=0x13` in cycle 1.
- Collision: `if_req=d_req=1` with a load to 0x2000 → `d_gnt=1`, `if_gnt=0`, `mem_addr=0x2000`; the IF read is granted the next cycle once `d_req` drops; `d_rvalid` then `if_rvalid` on consecutive cycles.
- Store: `d_req=1`, `d_we=1`, `d_addr=0x40`, `d_wdata=0xDEADBEEF`, `d_wstrb=4'b0011` → `mem_we=1`, `mem_wstrb=0011`, `d_gnt=1`; no `d_rvalid` follows; `busy` stays 0.
- Starvation, STARVE_MAX=4: hold both requests high continuously → grant sequence D,D,D,D,IF,D,D,D,D,IF; `starve_cnt` returns to 0 after each IF grant.
- Pipelined reads, MEM_LAT=3: alternating IF/D reads on cycles 0–5 → rvalids on cycles 3–8 with matching owners and data, never both rvalids in one cycle.
